// File: rtl/cam_pkg.sv
// Shared types and elaboration helpers for the CAM match encoder slice.
// Consumers: cam_priority_pick and cam_match_encoder (CAM_MATCH_ENC_MSB_FIRST_EN selects pick order).
package cam_pkg;

  localparam int CAM_DEPTH_DEF = 8;
  localparam int CAM_WIDTH_DEF = 8;
  localparam int CAM_MAX_DEPTH = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } cam_state_e;

  // Ceiling log2, never below 1 so a single-row CAM still has a 1-bit address.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  function automatic int popcount(input logic [CAM_MAX_DEPTH-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < CAM_MAX_DEPTH; i++) begin
      c = c + int'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/cam_priority_pick.sv
// Combinational find-first-set over the pending hit vector.
// LSB-first by default; CAM_MATCH_ENC_MSB_FIRST_EN picks the highest set bit instead.
module cam_priority_pick #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic [DEPTH-1:0] pending_i,
  output logic [AW-1:0]    idx_o,
  output logic [DEPTH-1:0] clr_mask_o,
  output logic             single_o
);

  logic found_s;

  // Select the highest-priority pending row and flag whether it is the only one.
  always_comb begin
    idx_o      = '0;
    clr_mask_o = '0;
    found_s    = 1'b0;
`ifdef CAM_MATCH_ENC_MSB_FIRST_EN
    for (int i = DEPTH - 1; i >= 0; i--) begin
`else
    for (int i = 0; i < DEPTH; i++) begin
`endif
      if (!found_s && pending_i[i]) begin
        idx_o         = AW'(i);
        clr_mask_o[i] = 1'b1;
        found_s       = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    single_o = (pending_i != '0) && ((pending_i & ~clr_mask_o) == '0);
  end

endmodule

// File: rtl/cam_match_encoder.sv
// Captures one CAM match vector and streams each hit as an encoded address, one per handshake.
// Build option: CAM_MATCH_ENC_MSB_FIRST_EN reverses priority (highest row first).
module cam_match_encoder
  import cam_pkg::*;
#(
  parameter  int CAM_DEPTH  = CAM_DEPTH_DEF,
  localparam int ADDR_WIDTH = clog2(CAM_DEPTH),
  localparam int CNT_WIDTH  = clog2(CAM_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  match_valid,
  input  logic [CAM_DEPTH-1:0]  match_vector,
  output logic                  match_ready,
  output logic                  addr_valid,
  input  logic                  addr_ready,
  output logic [ADDR_WIDTH-1:0] match_addr,
  output logic                  addr_last,
  output logic [CNT_WIDTH-1:0]  match_count,
  output logic                  no_match
);

  cam_state_e            state_q, state_d;
  logic [CAM_DEPTH-1:0]  pending_q, pending_d;
  logic [CAM_DEPTH-1:0]  clr_mask_q;
  logic [CNT_WIDTH-1:0]  match_count_q, match_count_d;
  logic                  no_match_q, no_match_d;
  logic                  match_ready_q, addr_valid_q, addr_last_q;
  logic [ADDR_WIDTH-1:0] match_addr_q;
  logic [CAM_MAX_DEPTH-1:0] vec_ext_s;
  logic [ADDR_WIDTH-1:0] pick_idx_s;
  logic [CAM_DEPTH-1:0]  pick_clr_s;
  logic                  pick_single_s;

  // The pick looks at next-state pending so address outputs can be registered.
  cam_priority_pick #(
    .DEPTH (CAM_DEPTH),
    .AW    (ADDR_WIDTH)
  ) u_pick (
    .pending_i  (pending_d),
    .idx_o      (pick_idx_s),
    .clr_mask_o (pick_clr_s),
    .single_o   (pick_single_s)
  );

  // Zero-extend the incoming vector for the package popcount helper.
  always_comb begin
    vec_ext_s                = '0;
    vec_ext_s[CAM_DEPTH-1:0] = match_vector;
  end

  // Next-state: capture in IDLE, retire one hit per transfer in SCAN.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    match_count_d = match_count_q;
    no_match_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (match_valid) begin
          pending_d     = match_vector;
          match_count_d = CNT_WIDTH'(popcount(vec_ext_s));
          if (match_vector == '0) begin
            no_match_d = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = SCAN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (addr_valid_q && addr_ready) begin
          pending_d = pending_q & ~clr_mask_q;
          if (addr_last_q) begin
            state_d = IDLE;
          end else begin
            state_d = SCAN;
          end
        end else begin
          state_d = SCAN;
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

  // State and registered outputs; reset discards any scan in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      clr_mask_q    <= '0;
      match_count_q <= '0;
      no_match_q    <= 1'b0;
      match_ready_q <= 1'b1;
      addr_valid_q  <= 1'b0;
      match_addr_q  <= '0;
      addr_last_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      clr_mask_q    <= pick_clr_s;
      match_count_q <= match_count_d;
      no_match_q    <= no_match_d;
      match_ready_q <= (state_d == IDLE);
      addr_valid_q  <= (state_d == SCAN);
      match_addr_q  <= (state_d == SCAN) ? pick_idx_s : '0;
      addr_last_q   <= (state_d == SCAN) && pick_single_s;
    end
  end

  assign match_ready = match_ready_q;
  assign addr_valid  = addr_valid_q;
  assign match_addr  = match_addr_q;
  assign addr_last   = addr_last_q;
  assign match_count = match_count_q;
  assign no_match    = no_match_q;

endmodule

// File: tb/tb_cam_match_encoder.sv
// Directed bench for cam_match_encoder: vector table plus stall, ignore and reset sequences.
// Expected address order follows CAM_MATCH_ENC_MSB_FIRST_EN when defined.
module tb_cam_match_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       match_valid;
  logic [7:0] match_vector;
  logic       match_ready;
  logic       addr_valid;
  logic       addr_ready;
  logic [2:0] match_addr;
  logic       addr_last;
  logic [3:0] match_count;
  logic       no_match;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  vec;
    int          count;
    logic [23:0] addrs;
  } vec_t;

  vec_t tbl [6];

  always #5 clk = ~clk;

  cam_match_encoder #(.CAM_DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .match_valid  (match_valid),
    .match_vector (match_vector),
    .match_ready  (match_ready),
    .addr_valid   (addr_valid),
    .addr_ready   (addr_ready),
    .match_addr   (match_addr),
    .addr_last    (addr_last),
    .match_count  (match_count),
    .no_match     (no_match)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hit j of n from a list written in ascending row order.
  function automatic logic [2:0] exp_addr(input logic [23:0] a, input int n, input int j);
`ifdef CAM_MATCH_ENC_MSB_FIRST_EN
    return a[3*(n-1-j) +: 3];
`else
    return a[3*j +: 3];
`endif
  endfunction

  task automatic capture(input logic [7:0] vec);
    chk("ready_before_capture", {31'd0, match_ready}, 32'd1);
    match_valid  = 1'b1;
    match_vector = vec;
    @(posedge clk);
    #1;
    match_valid  = 1'b0;
    match_vector = 8'h00;
  endtask

  task automatic run_entry(input vec_t e);
    capture(e.vec);
    if (e.count == 0) begin
      @(negedge clk);
      chk("nm_pulse", {31'd0, no_match}, 32'd1);
      chk("nm_valid", {31'd0, addr_valid}, 32'd0);
      chk("nm_ready", {31'd0, match_ready}, 32'd1);
      chk("nm_count", {28'd0, match_count}, 32'd0);
      @(negedge clk);
      chk("nm_pulse_end", {31'd0, no_match}, 32'd0);
      chk("nm_valid2", {31'd0, addr_valid}, 32'd0);
    end else begin
      for (int j = 0; j < e.count; j++) begin
        @(negedge clk);
        chk("tbl_valid", {31'd0, addr_valid}, 32'd1);
        chk("tbl_busy", {31'd0, match_ready}, 32'd0);
        chk("tbl_addr", {29'd0, match_addr}, {29'd0, exp_addr(e.addrs, e.count, j)});
        chk("tbl_last", {31'd0, addr_last}, {31'd0, (j == e.count - 1)});
        chk("tbl_count", {28'd0, match_count}, e.count);
      end
      @(negedge clk);
      chk("tbl_done_valid", {31'd0, addr_valid}, 32'd0);
      chk("tbl_done_ready", {31'd0, match_ready}, 32'd1);
      chk("tbl_done_count", {28'd0, match_count}, e.count);
    end
  endtask

  initial begin
    tbl[0] = '{8'h11, 2, {18'd0, 3'd4, 3'd0}};
    tbl[1] = '{8'h00, 0, 24'd0};
    tbl[2] = '{8'h80, 1, {21'd0, 3'd7}};
    tbl[3] = '{8'hA5, 4, {12'd0, 3'd7, 3'd5, 3'd2, 3'd0}};
    tbl[4] = '{8'h3C, 4, {12'd0, 3'd5, 3'd4, 3'd3, 3'd2}};
    tbl[5] = '{8'h01, 1, {21'd0, 3'd0}};

    rst          = 1'b0;
    match_valid  = 1'b0;
    match_vector = 8'h00;
    addr_ready   = 1'b1;
    #12;
    chk("rst_valid", {31'd0, addr_valid}, 32'd0);
    chk("rst_addr", {29'd0, match_addr}, 32'd0);
    chk("rst_last", {31'd0, addr_last}, 32'd0);
    chk("rst_count", {28'd0, match_count}, 32'd0);
    chk("rst_nomatch", {31'd0, no_match}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_ready", {31'd0, match_ready}, 32'd1);

    for (int i = 0; i < 6; i++) begin
      run_entry(tbl[i]);
    end

    // Stall with all rows hit: address holds, then drains one per cycle.
    addr_ready = 1'b0;
    capture(8'hFF);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, addr_valid}, 32'd1);
      chk("stall_addr", {29'd0, match_addr}, {29'd0, exp_addr(24'o76543210, 8, 0)});
      chk("stall_last", {31'd0, addr_last}, 32'd0);
    end
    chk("stall_count", {28'd0, match_count}, 32'd8);
    addr_ready = 1'b1;
    for (int j = 1; j < 8; j++) begin
      @(negedge clk);
      chk("drain_addr", {29'd0, match_addr}, {29'd0, exp_addr(24'o76543210, 8, j)});
      chk("drain_last", {31'd0, addr_last}, {31'd0, (j == 7)});
    end
    @(negedge clk);
    chk("drain_idle", {31'd0, addr_valid}, 32'd0);

    // A second vector offered during the scan must be ignored.
    capture(8'h81);
    match_valid  = 1'b1;
    match_vector = 8'h02;
    @(negedge clk);
    chk("ign_addr0", {29'd0, match_addr}, {29'd0, exp_addr({18'd0, 3'd7, 3'd0}, 2, 0)});
    chk("ign_last0", {31'd0, addr_last}, 32'd0);
    @(negedge clk);
    chk("ign_addr1", {29'd0, match_addr}, {29'd0, exp_addr({18'd0, 3'd7, 3'd0}, 2, 1)});
    chk("ign_last1", {31'd0, addr_last}, 32'd1);
    match_valid  = 1'b0;
    match_vector = 8'h00;
    @(negedge clk);
    chk("ign_idle", {31'd0, addr_valid}, 32'd0);
    chk("ign_count", {28'd0, match_count}, 32'd2);
    @(negedge clk);
    chk("ign_stay_idle", {31'd0, addr_valid}, 32'd0);

    // Asynchronous reset in the middle of a scan.
    capture(8'hF0);
    @(negedge clk);
    chk("rs_addr0", {29'd0, match_addr}, {29'd0, exp_addr({12'd0, 3'd7, 3'd6, 3'd5, 3'd4}, 4, 0)});
    @(negedge clk);
    chk("rs_addr1", {29'd0, match_addr}, {29'd0, exp_addr({12'd0, 3'd7, 3'd6, 3'd5, 3'd4}, 4, 1)});
    rst = 1'b0;
    #1;
    chk("rs_valid", {31'd0, addr_valid}, 32'd0);
    chk("rs_addr", {29'd0, match_addr}, 32'd0);
    chk("rs_last", {31'd0, addr_last}, 32'd0);
    chk("rs_count", {28'd0, match_count}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rs_rel_ready", {31'd0, match_ready}, 32'd1);
    chk("rs_rel_valid", {31'd0, addr_valid}, 32'd0);
    chk("rs_rel_count", {28'd0, match_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cam_match_encoder.md
Name: cam_match_encoder

Overview:
- Downstream consumer of the CAM wrapper's one-hot/multi-hot `decoded_match_address` (BCAM, TCAM or STCAM flavour).
- Captures one match vector per request and emits every matching row as an encoded binary address, one per handshake, in priority order.
- Reports the match count, last-address and no-match status to the lookup controller.

Parameters:
- CAM_DEPTH, 8, number of CAM rows; width of the match vector.
- ADDR_WIDTH, $clog2(CAM_DEPTH), derived localparam; encoded address width.
- CNT_WIDTH, $clog2(CAM_DEPTH+1), derived localparam; match count width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- match_valid  input  1  match_vector is valid this cycle.
- match_vector  input  CAM_DEPTH  decoded match address from the CAM wrapper.
- match_ready  output  1  encoder can accept a vector; high only in IDLE.
- addr_valid  output  1  match_addr holds a valid encoded hit.
- addr_ready  input  1  consumer accepts match_addr this cycle.
- match_addr  output  ADDR_WIDTH  encoded index of the current highest-priority pending hit.
- addr_last  output  1  current match_addr is the final pending hit.
- match_count  output  CNT_WIDTH  popcount of the captured vector, held until next capture.
- no_match  output  1  one-cycle pulse when a captured vector is all zero.

Behaviour:
- Reset (rst=0, async): state=IDLE, pending=0, match_count=0, no_match=0, addr_valid=0, match_addr=0, addr_last=0, match_ready=1 after release.
- States: IDLE, SCAN.
- IDLE:
  - match_ready=1.
  - On match_valid: pending<=match_vector and match_count<=popcount(match_vector).
  - If the vector is 0: no_match<=1 for exactly one cycle, stay in IDLE.
  - Otherwise go to SCAN.
- SCAN:
  - match_ready=0; match_valid and match_vector are ignored.
  - addr_valid=1.
  - match_addr=index of the lowest set bit of pending (LSB = row 0 = highest priority).
  - addr_last=1 iff exactly one bit of pending is set.
- Handshake: a transfer occurs when addr_valid&&addr_ready at a rising edge.
  - On transfer, clear that bit in pending.
  - If it was the last bit, go to IDLE.
  - Without addr_ready, match_addr, addr_last and pending hold stable.
- Latency:
  - Vector accepted at edge N; first addr_valid is high after edge N.
  - A k-hit vector needs k handshake cycles.
  - Next vector can be accepted at edge N+k+1 (one bubble in IDLE).
- match_addr and addr_last are driven only from registered state (pending, state); there is no combinational path from match_vector or addr_ready to the outputs.
- match_count is never cleared by the scan; it updates only on capture and reset.
- Reset asserted mid-SCAN: pending is discarded and all outputs return to reset values immediately (async).
- CAM_DEPTH=1: ADDR_WIDTH forced to 1, match_addr always 0.

Optional Feature:
- Macro: CAM_MATCH_ENC_MSB_FIRST_EN.
- Defined: priority reversed; match_addr is the highest set bit of pending (row CAM_DEPTH-1 first). addr_last is unchanged in meaning.
- Undefined: LSB-first as above.
- Count, no_match and handshake behaviour are identical in both builds.

Decomposition:
- Shared package cam_pkg:
  - CAM_DEPTH/CAM_WIDTH defaults (8/8).
  - State enum {IDLE, SCAN}.
  - clog2 helper function.
  - popcount function.
- One natural sub-module: cam_priority_pick, a combinational find-first-set.
  - Input: pending. Outputs: index, one-hot clear mask, single-bit flag.
  - Direction selected by CAM_MATCH_ENC_MSB_FIRST_EN.

Test Plan:
- Vector 8'h11, addr_ready=1 → match_count=2; match_addr 0 then 4; addr_last only with 4; match_ready back high one cycle after the second transfer.
- Vector 8'h00 → no_match high exactly one cycle, match_count=0, addr_valid never asserts, remains IDLE.
- Vector 8'hFF, addr_ready low for 5 cycles then high → match_addr holds 0 while stalled, then 0..7 on consecutive cycles, addr_last on 7, match_count=8.
- Vector 8'h81 captured, second match_valid 8'h02 presented during SCAN → second vector ignored; outputs 0, 7 only.
- Vector 8'hF0, rst pulled low after first transfer (addr 4) → outputs zero immediately; after release match_ready=1, addr_valid=0, match_count=0.
- With CAM_MATCH_ENC_MSB_FIRST_EN defined, vector 8'h81 → match_addr 7 then 0, addr_last on 0.
